// File: rtl/am_class_streamer_if.sv
// Handshake/bus bundle for am_class_streamer: class HV loading, stream control
// and the class HV stream toward the associative memory.
interface am_class_streamer_if #(
    parameter int HVDimension = 512,
    parameter int DataWidth   = 8
);
    logic                   load_en_i;
    logic [DataWidth-1:0]   load_addr_i;
    logic [HVDimension-1:0] load_hv_i;
    logic                   stream_start_i;
    logic [DataWidth-1:0]   csr_num_class_i;
    logic                   stream_busy_o;
    logic                   stream_done_o;
    logic [HVDimension-1:0] class_hv_o;
    logic                   class_hv_valid_o;
    logic                   class_hv_ready_i;
    logic [DataWidth-1:0]   class_idx_o;

    modport master (
        output load_en_i, load_addr_i, load_hv_i, stream_start_i,
               csr_num_class_i, class_hv_ready_i,
        input  stream_busy_o, stream_done_o, class_hv_o,
               class_hv_valid_o, class_idx_o
    );

    modport slave (
        input  load_en_i, load_addr_i, load_hv_i, stream_start_i,
               csr_num_class_i, class_hv_ready_i,
        output stream_busy_o, stream_done_o, class_hv_o,
               class_hv_valid_o, class_idx_o
    );
endinterface

// File: rtl/am_class_streamer.sv
// Class hypervector store that streams the first N entries, one per accepted
// handshake, to an associative memory. Loads are only taken while idle.
module am_class_streamer #(
    parameter int HVDimension = 512,
    parameter int DataWidth   = 8,
    parameter int NumClass    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    am_class_streamer_if.slave bus
);
    localparam int IdxW = (NumClass > 1) ? $clog2(NumClass) : 1;
    // One extra bit so N = NumClass = 2^DataWidth is representable.
    localparam int CntW = DataWidth + 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   idx_q, idx_d;
    logic [CntW-1:0]        n_q, n_d;
    logic                   done_q, done_d;
    logic [HVDimension-1:0] mem_q [NumClass];
    logic [HVDimension-1:0] mem_d [NumClass];

    logic [CntW-1:0]        csr_n;
    logic                   write_en;
    logic                   handshake;
    logic                   last;

    always_comb begin
        csr_n = {1'b0, bus.csr_num_class_i};
        if (csr_n > CntW'(NumClass)) begin
            csr_n = CntW'(NumClass);
        end
    end

    assign write_en  = bus.load_en_i && (state_q == IDLE) &&
                       (32'(bus.load_addr_i) < NumClass);
    assign handshake = (state_q == STREAM) && bus.class_hv_ready_i;
    assign last      = ({1'b0, idx_q} == (n_q - CntW'(1)));

    always_comb begin
        for (int i = 0; i < NumClass; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (write_en) begin
            mem_d[bus.load_addr_i[IdxW-1:0]] = bus.load_hv_i;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Also covers the done cycle: IDLE has already been entered.
                if (bus.stream_start_i && (csr_n != '0)) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    n_d     = csr_n;
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + DataWidth'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NumClass; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            done_q  <= done_d;
            for (int i = 0; i < NumClass; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.stream_busy_o    = (state_q == STREAM);
    assign bus.class_hv_valid_o = (state_q == STREAM);
    assign bus.stream_done_o    = done_q;
    assign bus.class_idx_o      = idx_q;
    assign bus.class_hv_o       = mem_q[idx_q[IdxW-1:0]];
endmodule

// File: tb/tb_am_class_streamer.sv
// Directed bench for am_class_streamer: load, stream, backpressure, CSR clamp,
// blocked writes, reset abort and start/done overlap.
module tb_am_class_streamer;
    localparam int HVD = 512;
    localparam int DW  = 8;
    localparam int NC  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    am_class_streamer_if #(.HVDimension(HVD), .DataWidth(DW)) bus ();

    am_class_streamer #(.HVDimension(HVD), .DataWidth(DW), .NumClass(NC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [HVD-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'(i) * 32'h9E37_79B9 + 32'h0000_1234;
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [HVD-1:0] obs, input logic [HVD-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, HVD'(bus.stream_busy_o), HVD'(0));
        chk({tag, "_valid"}, HVD'(bus.class_hv_valid_o), HVD'(0));
        chk({tag, "_idx"}, HVD'(bus.class_idx_o), HVD'(0));
    endtask

    task automatic chk_beat(input string tag, input int k, input logic [HVD-1:0] hv);
        chk({tag, "_valid"}, HVD'(bus.class_hv_valid_o), HVD'(1));
        chk({tag, "_busy"}, HVD'(bus.stream_busy_o), HVD'(1));
        chk({tag, "_idx"}, HVD'(bus.class_idx_o), HVD'(k));
        chk({tag, "_hv"}, bus.class_hv_o, hv);
        chk({tag, "_nodone"}, HVD'(bus.stream_done_o), HVD'(0));
    endtask

    initial begin
        bus.load_en_i        = 1'b0;
        bus.load_addr_i      = '0;
        bus.load_hv_i        = '0;
        bus.stream_start_i   = 1'b0;
        bus.csr_num_class_i  = '0;
        bus.class_hv_ready_i = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_done", HVD'(bus.stream_done_o), HVD'(0));
        chk("reset_hv", bus.class_hv_o, '0);

        // Load all entries, then an out-of-range address that must be dropped
        for (int i = 0; i < NC; i++) begin
            bus.load_en_i   = 1'b1;
            bus.load_addr_i = DW'(i);
            bus.load_hv_i   = pat(i);
            tick();
        end
        bus.load_addr_i = DW'(16);
        bus.load_hv_i   = {HVD{1'b1}};
        tick();
        bus.load_en_i = 1'b0;

        // Four classes, ready held high
        bus.csr_num_class_i  = DW'(4);
        bus.class_hv_ready_i = 1'b1;
        bus.stream_start_i   = 1'b1;
        tick();
        bus.stream_start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("s4_%0d", k), k, pat(k));
            tick();
        end
        chk("s4_done", HVD'(bus.stream_done_o), HVD'(1));
        chk_idle("s4_end");
        tick();
        chk("s4_done_gone", HVD'(bus.stream_done_o), HVD'(0));

        // Three classes, ready 1,0,0,1,1
        bus.csr_num_class_i = DW'(3);
        bus.stream_start_i  = 1'b1;
        tick();
        bus.stream_start_i = 1'b0;
        chk_beat("bp_a", 0, pat(0));
        tick();
        chk_beat("bp_b", 1, pat(1));
        bus.class_hv_ready_i = 1'b0;
        tick();
        chk_beat("bp_c", 1, pat(1));
        tick();
        chk_beat("bp_d", 1, pat(1));
        bus.class_hv_ready_i = 1'b1;
        tick();
        chk_beat("bp_e", 2, pat(2));
        tick();
        chk("bp_done", HVD'(bus.stream_done_o), HVD'(1));
        chk_idle("bp_end");

        // Zero count is ignored
        bus.csr_num_class_i = DW'(0);
        bus.stream_start_i  = 1'b1;
        tick();
        bus.stream_start_i = 1'b0;
        chk_idle("zero_a");
        chk("zero_nodone_a", HVD'(bus.stream_done_o), HVD'(0));
        tick();
        chk("zero_nodone_b", HVD'(bus.stream_done_o), HVD'(0));

        // Count 200 clamps to 16; CSR change after start has no effect
        bus.csr_num_class_i = DW'(200);
        bus.stream_start_i  = 1'b1;
        tick();
        bus.stream_start_i  = 1'b0;
        bus.csr_num_class_i = DW'(1);
        for (int k = 0; k < NC; k++) begin
            chk_beat($sformatf("clamp_%0d", k), k, pat(k));
            tick();
        end
        chk("clamp_done", HVD'(bus.stream_done_o), HVD'(1));
        chk_idle("clamp_end");

        // Write to entry 1 during a stream is blocked
        bus.csr_num_class_i  = DW'(3);
        bus.class_hv_ready_i = 1'b0;
        bus.stream_start_i   = 1'b1;
        tick();
        bus.stream_start_i = 1'b0;
        chk_beat("wb_a", 0, pat(0));
        bus.load_en_i        = 1'b1;
        bus.load_addr_i      = DW'(1);
        bus.load_hv_i        = {HVD{1'b1}};
        bus.class_hv_ready_i = 1'b1;
        tick();
        bus.load_en_i = 1'b0;
        chk_beat("wb_b", 1, pat(1));
        tick();
        chk_beat("wb_c", 2, pat(2));
        tick();
        chk("wb_done", HVD'(bus.stream_done_o), HVD'(1));
        bus.csr_num_class_i = DW'(2);
        bus.stream_start_i  = 1'b1;
        tick();
        bus.stream_start_i = 1'b0;
        chk_beat("wb_rd0", 0, pat(0));
        tick();
        chk_beat("wb_rd1", 1, pat(1));
        tick();
        chk("wb_rd_done", HVD'(bus.stream_done_o), HVD'(1));

        // Start while busy ignored; start coincident with done accepted
        bus.csr_num_class_i = DW'(3);
        bus.stream_start_i  = 1'b1;
        tick();
        chk_beat("ov_a", 0, pat(0));
        tick();
        bus.stream_start_i = 1'b0;
        chk_beat("ov_b", 1, pat(1));
        tick();
        chk_beat("ov_c", 2, pat(2));
        tick();
        chk("ov_done", HVD'(bus.stream_done_o), HVD'(1));
        chk("ov_done_busy", HVD'(bus.stream_busy_o), HVD'(0));
        bus.csr_num_class_i = DW'(2);
        bus.stream_start_i  = 1'b1;
        tick();
        bus.stream_start_i = 1'b0;
        chk_beat("ov_re0", 0, pat(0));
        tick();
        chk_beat("ov_re1", 1, pat(1));
        tick();
        chk("ov_re_done", HVD'(bus.stream_done_o), HVD'(1));

        // Reset at idx 2 of a five-class stream
        bus.csr_num_class_i = DW'(5);
        bus.stream_start_i  = 1'b1;
        tick();
        bus.stream_start_i = 1'b0;
        tick();
        tick();
        chk_beat("rs_pre", 2, pat(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rs_post");
        chk("rs_post_done", HVD'(bus.stream_done_o), HVD'(0));
        chk("rs_post_hv", bus.class_hv_o, '0);
        tick();
        chk("rs_nodone", HVD'(bus.stream_done_o), HVD'(0));
        bus.csr_num_class_i = DW'(4);
        bus.stream_start_i  = 1'b1;
        tick();
        bus.stream_start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("rs_zero_%0d", k), k, '0);
            tick();
        end
        chk("rs_zero_done", HVD'(bus.stream_done_o), HVD'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/am_class_streamer.md
AM_CLASS_STREAMER -- requirements
Module: am_class_streamer

Interface
- REQ-001: Parameter HVDimension, default 512, hypervector width in bits.
- REQ-002: Parameter DataWidth, default 8, width of the index, count and CSR fields.
- REQ-003: Parameter NumClass, default 16, number of class HV storage entries (NumClass <= 2^DataWidth).
- REQ-004: clk_i  input  1  single clock; all state updates on its rising edge.
- REQ-005: rst_i  input  1  reset, synchronous, active-high.
- REQ-006: load_en_i  input  1  write strobe for class HV storage.
- REQ-007: load_addr_i  input  DataWidth  storage entry to write.
- REQ-008: load_hv_i  input  HVDimension  class HV to write.
- REQ-009: stream_start_i  input  1  request to stream all active classes.
- REQ-010: csr_num_class_i  input  DataWidth  number of classes to stream.
- REQ-011: stream_busy_o  output  1  high while a stream is in progress.
- REQ-012: stream_done_o  output  1  one-cycle pulse after the final class is accepted.
- REQ-013: class_hv_o  output  HVDimension  class HV presented to the associative memory.
- REQ-014: class_hv_valid_o  output  1  class_hv_o holds a valid entry.
- REQ-015: class_hv_ready_i  input  1  consumer accepts class_hv_o this cycle.
- REQ-016: class_idx_o  output  DataWidth  index of the entry currently on class_hv_o.

Function
- REQ-017: Storage SHALL be NumClass registers of HVDimension bits; class_hv_o SHALL equal entry[class_idx_o] combinationally.
- REQ-018: A write SHALL occur when load_en_i=1, stream_busy_o=0 and load_addr_i < NumClass; otherwise the write SHALL be dropped silently.
- REQ-019: Effective count N SHALL be min(csr_num_class_i, NumClass), sampled into a register on the accepted start; later CSR changes SHALL NOT affect the running stream.
- REQ-020: FSM SHALL have two states: IDLE and STREAM.
- REQ-021: IDLE -> STREAM when stream_start_i=1 and N>0; class_idx_o SHALL be 0 on entry.
- REQ-022: stream_start_i with N=0 SHALL be ignored (remain IDLE, no done pulse).
- REQ-023: stream_start_i while in STREAM SHALL be ignored.
- REQ-024: stream_busy_o and class_hv_valid_o SHALL both be high exactly when in STREAM; start at cycle t gives valid high from cycle t+1.
- REQ-025: Handshake occurs when class_hv_valid_o=1 and class_hv_ready_i=1; class_hv_o and class_idx_o SHALL remain stable until a handshake.
- REQ-026: On a handshake with class_idx_o < N-1, class_idx_o SHALL increment by 1 next cycle; with ready held high, one entry SHALL transfer per cycle.
- REQ-027: On a handshake with class_idx_o = N-1, next cycle SHALL be IDLE, class_idx_o = 0, valid low and stream_done_o = 1 for exactly that one cycle.
- REQ-028: A start in the same cycle as stream_done_o=1 SHALL be accepted (IDLE is already entered).
- REQ-029: class_idx_o SHALL never exceed N-1; no wrap-around past N.
- REQ-030: Writes blocked during STREAM SHALL guarantee the streamed data equals storage contents at start.

Reset
- REQ-031: rst_i=1 SHALL force IDLE, stream_busy_o=0, class_hv_valid_o=0, stream_done_o=0, class_idx_o=0, stored N=0 and all storage entries to 0.
- REQ-032: rst_i asserted mid-stream SHALL abort the stream without a done pulse; outputs SHALL reach reset values on the next cycle.

Verification
- REQ-033: Load entries 0..3 with distinct patterns, csr=4, start, ready held high -> valid cycles t+1..t+4 with idx 0,1,2,3 and matching HVs; done=1 at t+5, busy=0.
- REQ-034: csr=3, ready toggled 1,0,0,1,1 -> each idx held stable while ready=0; exactly 3 handshakes; done one cycle after idx 2 accepted.
- REQ-035: csr=0, start -> busy stays 0, no valid, no done; csr=200 with NumClass=16 -> exactly 16 handshakes, idx 0..15.
- REQ-036: load_en_i=1 to addr 1 during stream -> streamed entry 1 unchanged, storage unchanged after done; load to addr 16 (NumClass=16) in IDLE -> no write.
- REQ-037: rst_i asserted at idx 2 of a 5-class stream -> next cycle busy=0, valid=0, idx=0, done=0, entries read back as 0.
- REQ-038: Start pulsed while busy, and start coincident with done -> first ignored; second begins a new stream with valid high on the following cycle.
